// File: rtl/mbox_err_if.sv
// Handshake bundle between the MBOX error detectors / EBOX and the error arbiter.
// The master drives error strobes, mask, ack and clear; the slave reports page fails.
interface mbox_err_if #(
  parameter int N_SRC  = 5,
  parameter int ADDR_W = 27,
  parameter int PFD_W  = 11,
  parameter int CNT_W  = 4
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]  err_in;
  logic [N_SRC-1:0]  err_mask;
  logic [ADDR_W-1:0] err_addr;
  logic              ebox_ack;
  logic              clr;

  logic              pf_hold;
  logic [PFD_W-1:0]  pf_disp;
  logic [SRC_W-1:0]  err_src;
  logic [ADDR_W-1:0] err_addr_q;
  logic              err_addr_vld;
  logic [N_SRC-1:0]  err_pend;
  logic [CNT_W-1:0]  lost_cnt;

  modport master (
    output err_in, err_mask, err_addr, ebox_ack, clr,
    input  pf_hold, pf_disp, err_src, err_addr_q, err_addr_vld, err_pend, lost_cnt
  );

  modport slave (
    input  err_in, err_mask, err_addr, ebox_ack, clr,
    output pf_hold, pf_disp, err_src, err_addr_q, err_addr_vld, err_pend, lost_cnt
  );
endinterface

// File: rtl/mbox_err_arbiter.sv
// MBOX error capture and page-fail arbiter: latches one error at a time, raises the
// page-fail hold/dispatch toward the EBOX and pends or counts errors arriving meanwhile.
//
//   state | meaning
//   IDLE  | no report outstanding; capture the highest-priority request
//   HOLD  | pf_hold high, waiting for ebox_ack
//   DRAIN | one forced pf_hold-low cycle between reports
module mbox_err_arbiter #(
  parameter int               N_SRC    = 5,
  parameter int               ADDR_W   = 27,
  parameter int               PFD_W    = 11,
  parameter logic [PFD_W-1:0] PFD_BASE = 11'o1400,
  parameter int               CNT_W    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mbox_err_if.slave bus
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int NL_W  = $clog2(N_SRC + 1);
  localparam int SUM_W = CNT_W + NL_W;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic              hold_q, hold_d;
  logic [PFD_W-1:0]  disp_q, disp_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  lost_q, lost_d;

  logic [N_SRC-1:0]  req;
  logic [N_SRC-1:0]  new_err;
  logic [N_SRC-1:0]  lost_bits;
  logic [SRC_W-1:0]  win;
  logic [NL_W-1:0]   n_lost;
  logic [SUM_W-1:0]  lost_sum;

  assign new_err = bus.err_in & ~bus.err_mask;
  assign req     = (bus.err_in | pend_q) & ~bus.err_mask;

  // Lowest set index wins.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) win = SRC_W'(i);
    end
  end

  always_comb begin
    lost_bits = '0;
    if (state_q == S_HOLD)  lost_bits = new_err & (pend_q | (N_SRC'(1) << src_q));
    if (state_q == S_DRAIN) lost_bits = new_err & pend_q;
  end

  always_comb begin
    n_lost = '0;
    for (int i = 0; i < N_SRC; i++) begin
      n_lost = n_lost + NL_W'(lost_bits[i]);
    end
  end

  assign lost_sum = SUM_W'(lost_q) + SUM_W'(n_lost);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (|req) state_d = S_HOLD;
        S_HOLD:  if (bus.ebox_ack) state_d = S_DRAIN;
        S_DRAIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hold_d = hold_q;
    disp_d = disp_q;
    src_d  = src_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    pend_d = pend_q;
    lost_d = lost_q;
    if (bus.clr) begin
      hold_d = 1'b0;
      disp_d = '0;
      src_d  = '0;
      addr_d = '0;
      vld_d  = 1'b0;
      pend_d = '0;
      lost_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            hold_d = 1'b1;
            disp_d = PFD_BASE + PFD_W'(win);
            src_d  = win;
            if (bus.err_in[win]) begin
              addr_d = bus.err_addr;
              vld_d  = 1'b1;
            end else begin
              vld_d  = 1'b0;
            end
            pend_d = (pend_q | new_err) & ~(N_SRC'(1) << win);
          end
        end
        S_HOLD, S_DRAIN: begin
          pend_d = pend_q | new_err;
          if (lost_sum > SUM_W'({CNT_W{1'b1}})) lost_d = '1;
          else                                  lost_d = lost_sum[CNT_W-1:0];
          if (state_q == S_HOLD && bus.ebox_ack) begin
            hold_d = 1'b0;
            disp_d = '0;
            vld_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      disp_q <= '0;
      src_q  <= '0;
      addr_q <= '0;
      vld_q  <= 1'b0;
      pend_q <= '0;
      lost_q <= '0;
    end else begin
      hold_q <= hold_d;
      disp_q <= disp_d;
      src_q  <= src_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      pend_q <= pend_d;
      lost_q <= lost_d;
    end
  end

  assign bus.pf_hold      = hold_q;
  assign bus.pf_disp      = disp_q;
  assign bus.err_src      = src_q;
  assign bus.err_addr_q   = addr_q;
  assign bus.err_addr_vld = vld_q;
  assign bus.err_pend     = pend_q;
  assign bus.lost_cnt     = lost_q;
endmodule
